// File: rtl/pwm_duty_pkg.sv
// Shared types and arithmetic helpers for the serial PWM duty loader.
package pwm_duty_pkg;

  localparam int DUTY_W     = 6;
  localparam int FRAME_BITS = 12;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } rx_state_t;

  function automatic duty_t clamp_duty(input duty_t d, input duty_t dmax);
    return (d > dmax) ? dmax : d;
  endfunction

  // One carrier period of slew: move cur toward tgt by at most step (0 = unlimited).
  function automatic duty_t slew_step(input duty_t cur, input duty_t tgt, input duty_t step);
    logic signed [DUTY_W:0] diff;
    logic signed [DUTY_W:0] lim;
    diff = signed'({1'b0, tgt}) - signed'({1'b0, cur});
    lim  = signed'({1'b0, step});
    if (step == '0)
      return tgt;
    if (diff > lim)
      return cur + step;
    if (diff < -lim)
      return cur - step;
    return tgt;
  endfunction

endpackage

// File: rtl/pwm_duty_loader_if.sv
// Serial pad inputs, carrier valley strobe and comparator-side duty outputs.
interface pwm_duty_loader_if
  import pwm_duty_pkg::*;
;
  logic  s_sclk;
  logic  s_mosi;
  logic  s_cs_n;
  logic  carrier_zero;
  duty_t duty1_o;
  duty_t duty2_o;
  logic  pending_o;
  logic  update_o;
  logic  frame_err_o;

  modport master (
    output s_sclk, s_mosi, s_cs_n, carrier_zero,
    input  duty1_o, duty2_o, pending_o, update_o, frame_err_o
  );

  modport slave (
    input  s_sclk, s_mosi, s_cs_n, carrier_zero,
    output duty1_o, duty2_o, pending_o, update_o, frame_err_o
  );
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser with registered rise/fall pulses on the synchronised level.
module sync_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_reg;
  logic       prev_reg;
  logic [2:0] prime_reg;
  logic       rise_reg;
  logic       fall_reg;

  // Edges stay masked until the flops hold real pad samples, so a pad level that
  // differs from RST_VAL at reset release is not mistaken for an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= {2{RST_VAL}};
      prev_reg  <= RST_VAL;
      prime_reg <= '0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], din};
      prev_reg  <= sync_reg[1];
      prime_reg <= {prime_reg[1:0], 1'b1};
      rise_reg  <= prime_reg[2] & sync_reg[1] & ~prev_reg;
      fall_reg  <= prime_reg[2] & ~sync_reg[1] & prev_reg;
    end
  end

  assign dout = sync_reg[1];
  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/pwm_duty_loader.sv
// Serial duty receiver with double buffering and slew-limited commit at the carrier valley.
module pwm_duty_loader
  import pwm_duty_pkg::*;
#(
  parameter duty_t D_MAX    = 6'd63,
  parameter duty_t MAX_STEP = 6'd4
) (
  input logic              clk,
  input logic              rst_n,
  pwm_duty_loader_if.slave bus
);

  localparam logic [3:0] CNT_SAT  = 4'd13;
  localparam logic [3:0] CNT_FULL = 4'(FRAME_BITS);

  logic sclk_rise, sclk_fall_unused, sclk_lvl_unused;
  logic cs_rise, cs_fall, cs_lvl_unused;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  sync_edge_det #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(bus.s_sclk),
    .dout(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  sync_edge_det #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(bus.s_mosi),
    .dout(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  sync_edge_det #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(bus.s_cs_n),
    .dout(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
  );

  rx_state_t             state_reg, state_next;
  logic [FRAME_BITS-1:0] shift_reg, shift_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic                  pending_reg;
  logic                  err_reg;
  logic                  update_reg;
  logic                  frame_ok;
  logic                  frame_bad;
  logic [1:0]            leg_change;
  duty_t                 duty_out [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          shift_next = '0;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shift_next = {shift_reg[FRAME_BITS-2:0], mosi_sync};
          if (cnt_reg != CNT_SAT)
            cnt_next = cnt_reg + 4'd1;
        end
        if (cs_rise)
          state_next = CHECK;
      end
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign frame_ok  = (state_reg == CHECK) && (cnt_reg == CNT_FULL);
  assign frame_bad = (state_reg == CHECK) && (cnt_reg != CNT_FULL);

  // A frame validated in the same cycle as carrier_zero stays pending; the older one commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= 1'b0;
      err_reg     <= 1'b0;
      update_reg  <= 1'b0;
    end else begin
      if (frame_ok)
        pending_reg <= 1'b1;
      else if (bus.carrier_zero)
        pending_reg <= 1'b0;
      if (frame_ok)
        err_reg <= 1'b0;
      else if (frame_bad)
        err_reg <= 1'b1;
      update_reg <= bus.carrier_zero & (|leg_change);
    end
  end

  // Leg 0 takes the first-sent field (duty1), leg 1 the second (duty2).
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_leg
    duty_t pend_reg;
    duty_t tgt_reg;
    duty_t out_reg;
    duty_t tgt_eff;
    duty_t out_next;

    assign tgt_eff  = pending_reg ? pend_reg : tgt_reg;
    assign out_next = slew_step(out_reg, tgt_eff, MAX_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pend_reg <= '0;
        tgt_reg  <= '0;
        out_reg  <= '0;
      end else begin
        if (frame_ok)
          pend_reg <= clamp_duty(shift_reg[(1-gi)*DUTY_W +: DUTY_W], D_MAX);
        if (bus.carrier_zero) begin
          tgt_reg <= tgt_eff;
          out_reg <= out_next;
        end
      end
    end

    assign leg_change[gi] = (out_next != out_reg);
    assign duty_out[gi]   = out_reg;
  end

  assign bus.duty1_o     = duty_out[0];
  assign bus.duty2_o     = duty_out[1];
  assign bus.pending_o   = pending_reg;
  assign bus.update_o    = update_reg;
  assign bus.frame_err_o = err_reg;

endmodule
